alarm_btn_ctrl: RTL and testbench
=================================

# alarm_btn_ctrl

Front-end button controller for the alarm clock: it takes the raw, bouncy, asynchronous push-button levels from the dedicated inputs and converts them into clean, debounced levels plus single-cycle command pulses. Buttons enabled by `REPEAT_MASK` also get hold-to-repeat pulses. It sits between `ui_in` and the clock/alarm core. It drives the core's set-hour, set-minute, alarm-toggle and mode inputs, and the core consumes only `press`.

## Interface
- `N_BTN`, 4: number of buttons (bit 0 hour, 1 minute, 2 alarm on/off, 3 mode).
- `DB_CYCLES`, 20000: cycles a synchronized level must stay stable before it is accepted; ≥2.
- `REPEAT_DELAY`, 500000: cycles from the initial press pulse to the first repeat pulse; ≥2.
- `REPEAT_RATE`, 100000: cycles between subsequent repeat pulses; ≥2.
- `REPEAT_MASK`, 4'b0011: buttons that auto-repeat; the others pulse once per press.
- `CNT_W`, 20: counter width; must hold max(DB_CYCLES, REPEAT_DELAY, REPEAT_RATE)−1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  design enable; when low, the block is held idle.
- `btn_raw`  in  N_BTN  raw button levels, active high, asynchronous to `clk`.
- `held`  out  N_BTN  debounced button level.
- `press`  out  N_BTN  one-cycle command pulse (initial press or repeat).
- `any_held`  out  1  OR of `held`.

## Operation
- Each button has a 2-FF synchronizer (`s1`, `s2`), a debounce counter `db_cnt` and a stable level `stab`, which drives `held`. Repeat buttons also have `rep_cnt` and a `rep_first` flag.
- Debounce, per button:
  - If `s2 == stab`, `db_cnt` is cleared.
  - Otherwise `db_cnt` increments.
  - When `db_cnt == DB_CYCLES−1` and the mismatch persists, `stab` takes `s2` at the next edge and `db_cnt` clears.
  - Any glitch that returns to `stab` before then restarts the count from 0.
- Press pulse: `press[i]` is high for exactly one cycle on the edge where `stab[i]` goes 0→1. Release (1→0) produces no pulse.
- Repeat FSM, per button with `REPEAT_MASK[i]=1`, states IDLE / WAIT_FIRST / REPEAT:
  - IDLE → WAIT_FIRST on the press edge, with `rep_cnt` = 0.
  - WAIT_FIRST: when `rep_cnt == REPEAT_DELAY−1`, pulse `press[i]`, clear `rep_cnt` and go to REPEAT.
  - REPEAT: when `rep_cnt == REPEAT_RATE−1`, pulse `press[i]` and clear `rep_cnt`.
  - In any state, `stab[i]` falling returns the FSM to IDLE with `rep_cnt` cleared; a pulse due on that edge is suppressed.
- Buttons are fully independent. Simultaneous presses give simultaneous pulses on each bit, with no priority or arbitration.
- `ena` low:
  - Synchronizers keep sampling.
  - `db_cnt`, `rep_cnt` and `stab` are cleared, FSMs go to IDLE, and `press` is forced to 0.
  - On `ena` rising, a button already held is treated as a new press: a pulse follows after the debounce period.
- Counters never wrap. They are always cleared at their terminal value or by a mismatch/equality condition.

## Timing
- Reset (`rst_n` low, asynchronous): `s1`, `s2`, `stab`, `db_cnt`, `rep_cnt` = 0, all FSMs IDLE, and `held`, `press`, `any_held` = 0 immediately. Reset mid-hold discards the press; after release of reset, a held button produces a fresh pulse after DB_CYCLES+2 edges.
- All outputs are registered, except `any_held`, which is the OR of registered `held`.
- Press latency: a `btn_raw` change sampled at edge k gives `held` and `press` high after edge k+1+DB_CYCLES (2 synchronizer edges plus DB_CYCLES debounce edges).
- Release latency is the same for `held`.
- First repeat pulse: REPEAT_DELAY cycles after the initial press pulse. Later repeat pulses: every REPEAT_RATE cycles.
- Minimum accepted press width is DB_CYCLES cycles of stable `s2`.

## Test plan
Parameters for all scenarios: DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_MASK=4'b0011.

- Reset: assert `rst_n`=0 with `btn_raw`=4'hF → `held`=0, `press`=0, `any_held`=0. Release reset → `press`=4'hF for one cycle 6 edges later, then `press`=4'b0011 on repeat instants.
- Clean press of bit 2 for 20 cycles → exactly one `press[2]` pulse, 6 cycles after the input rises. `held[2]` is high from then until 6 cycles after the input falls.
- Bounce: toggle `btn_raw[1]` 1/0 every 2 cycles for 20 cycles, then hold high → no pulse during the bounce; a single pulse 6 cycles after the final rise.
- Repeat: hold `btn_raw[0]` for 40 cycles → pulses at t0 and t0+10, then every 3 cycles. Release → no further pulses and the FSM returns to IDLE.
- Simultaneous: raise bits 0 and 3 on the same cycle → `press`=4'b1001 on the same cycle. Only bit 0 repeats afterwards.
- Enable: drop `ena` mid-hold (in REPEAT) → `press` goes 0 and `held` clears. Raise `ena` with the button still down → a new pulse 4 cycles later (synchronizer already settled) and a repeat restart.

Source files
------------

// File: rtl/alarm_btn_ctrl.sv
// alarm_btn_ctrl: synchronizes and debounces the raw buttons, then issues
// one-cycle press pulses, with hold-to-repeat on the REPEAT_MASK buttons.
module alarm_btn_ctrl #(
  parameter int unsigned       N_BTN        = 4,
  parameter int unsigned       DB_CYCLES    = 20000,
  parameter int unsigned       REPEAT_DELAY = 500000,
  parameter int unsigned       REPEAT_RATE  = 100000,
  parameter logic [N_BTN-1:0]  REPEAT_MASK  = 4'b0011,
  parameter int unsigned       CNT_W        = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] held,
  output logic [N_BTN-1:0] press,
  output logic             any_held
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REP
  } rep_st_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  logic [N_BTN-1:0] s1_q;
  logic [N_BTN-1:0] s2_q;
  logic [N_BTN-1:0] stab_q;
  logic [N_BTN-1:0] stab_d;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] rep_pls;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] press_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;
    logic             stb_d;

    // Any return of s2 to the stable level restarts the count.
    always_comb begin
      db_cnt_d = '0;
      stb_d    = stab_q[i];
      if (!ena) begin
        stb_d = 1'b0;
      end else if (s2_q[i] != stab_q[i]) begin
        if (db_cnt_q == DB_LAST) begin
          stb_d = s2_q[i];
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_d;
      end
    end

    assign stab_d[i] = stb_d;

    if (REPEAT_MASK[i]) begin : g_rep
      rep_st_e          st_q;
      rep_st_e          st_d;
      logic [CNT_W-1:0] rep_cnt_q;
      logic [CNT_W-1:0] rep_cnt_d;
      logic             pls;

      always_comb begin
        st_d      = st_q;
        rep_cnt_d = '0;
        pls       = 1'b0;
        unique case (st_q)
          ST_IDLE: begin
            if (rise[i]) st_d = ST_WAIT;
          end
          ST_WAIT: begin
            if (rep_cnt_q == RD_LAST) begin
              pls  = 1'b1;
              st_d = ST_REP;
            end else begin
              rep_cnt_d = rep_cnt_q + CNT_W'(1);
            end
          end
          ST_REP: begin
            if (rep_cnt_q == RR_LAST) begin
              pls = 1'b1;
            end else begin
              rep_cnt_d = rep_cnt_q + CNT_W'(1);
            end
          end
          default: st_d = ST_IDLE;
        endcase
        // Release or disable wins over a pulse due on the same edge.
        if (!ena || fall[i]) begin
          st_d      = ST_IDLE;
          rep_cnt_d = '0;
          pls       = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          st_q      <= ST_IDLE;
          rep_cnt_q <= '0;
        end else begin
          st_q      <= st_d;
          rep_cnt_q <= rep_cnt_d;
        end
      end

      assign rep_pls[i] = pls;
    end else begin : g_norep
      assign rep_pls[i] = 1'b0;
    end
  end

  assign rise    = ~stab_q & stab_d;
  assign fall    = stab_q & ~stab_d;
  assign press_d = ena ? (rise | rep_pls) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      stab_q  <= '0;
      press_q <= '0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      stab_q  <= stab_d;
      press_q <= press_d;
    end
  end

  assign held     = stab_q;
  assign press    = press_q;
  assign any_held = |stab_q;

endmodule

// File: tb/tb_alarm_btn_ctrl.sv
// tb_alarm_btn_ctrl: directed button scenarios; expected press pulses are
// queued by cycle and matched by an independent monitor.
module tb_alarm_btn_ctrl;

  localparam logic [3:0] MASK = 4'b0011;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] btn_raw;
  logic [3:0] held;
  logic [3:0] press;
  logic       any_held;

  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];

  alarm_btn_ctrl #(
    .N_BTN       (4),
    .DB_CYCLES   (DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .REPEAT_MASK (MASK),
    .CNT_W       (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .btn_raw (btn_raw),
    .held    (held),
    .press   (press),
    .any_held(any_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_exp(int c, logic [3:0] v);
    exp_t t;
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].cyc == c) begin
        t = sb[k];
        t.val = t.val | v;
        sb[k] = t;
        return;
      end
      if (sb[k].cyc > c) begin
        t.cyc = c;
        t.val = v;
        sb.insert(k, t);
        return;
      end
    end
    t.cyc = c;
    t.val = v;
    sb.push_back(t);
  endtask

  // Initial pulse at p; repeats every RR after p+RD, all before stop.
  task automatic sched(int i, int p, int stop);
    logic [3:0] b;
    b = 4'b0001 << i;
    push_exp(p, b);
    if (MASK[i]) begin
      for (int c = p + RD; c < stop; c += RR) push_exp(c, b);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic go_to(int c);
    while (cyc < c) step();
  endtask

  // Monitor: every nonzero press must match the queue head exactly.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_pulse: got none at cyc=%0d want %0h",
               sb[0].cyc, sb[0].val);
      void'(sb.pop_front());
    end
    if (press != 4'b0000) begin
      total++;
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        bad++;
        $display("FAIL extra_pulse cyc=%0d: got %0h want none",
                 cyc, press);
      end else begin
        e = sb.pop_front();
        if (press !== e.val) begin
          bad++;
          $display("FAIL pulse_val cyc=%0d: got %0h want %0h",
                   cyc, press, e.val);
        end
      end
    end
  end

  initial begin
    int d;
    int f;
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    ena     = 1'b1;
    btn_raw = 4'hF;

    // Reset with all buttons down, then release reset.
    repeat (3) step();
    chk("rst_held", held, 4'h0);
    chk("rst_press", press, 4'h0);
    chk("rst_any", any_held, 1'b0);
    d = cyc;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) sched(i, d + 6, d + 26);
    go_to(d + 5);
    chk("rst_held_pre", held, 4'h0);
    go_to(d + 6);
    chk("rst_any_on", any_held, 1'b1);
    go_to(d + 20);
    btn_raw = 4'h0;
    go_to(d + 25);
    chk("rst_held_hi", held, 4'hF);
    go_to(d + 26);
    chk("rst_held_lo", held, 4'h0);
    chk("rst_any_off", any_held, 1'b0);
    go_to(d + 35);

    // Clean press of the alarm button.
    d = cyc;
    btn_raw[2] = 1'b1;
    sched(2, d + 6, d + 26);
    go_to(d + 5);
    chk("b2_held_pre", held, 4'h0);
    go_to(d + 6);
    chk("b2_held_on", held, 4'h4);
    go_to(d + 20);
    btn_raw[2] = 1'b0;
    go_to(d + 25);
    chk("b2_held_hold", held, 4'h4);
    go_to(d + 26);
    chk("b2_held_off", held, 4'h0);
    go_to(d + 30);

    // Bounce on the minute button, then a solid hold.
    d = cyc;
    for (int k = 0; k < 10; k++) begin
      btn_raw[1] = (k % 2 == 0);
      go_to(d + 2 * (k + 1));
    end
    btn_raw[1] = 1'b1;
    sched(1, d + 26, d + 38);
    go_to(d + 25);
    chk("bnc_held_pre", held, 4'h0);
    go_to(d + 26);
    chk("bnc_held_on", held, 4'h2);
    go_to(d + 32);
    btn_raw[1] = 1'b0;
    go_to(d + 42);

    // Width DB-1 is rejected, width DB is accepted.
    d = cyc;
    btn_raw[3] = 1'b1;
    go_to(d + 3);
    btn_raw[3] = 1'b0;
    go_to(d + 12);
    chk("short_held", held, 4'h0);
    d = cyc;
    btn_raw[3] = 1'b1;
    sched(3, d + 6, d + 10);
    go_to(d + 4);
    btn_raw[3] = 1'b0;
    go_to(d + 9);
    chk("min_held_on", held, 4'h8);
    go_to(d + 10);
    chk("min_held_off", held, 4'h0);
    go_to(d + 15);

    // Hold-to-repeat; release lands exactly on a due repeat.
    d = cyc;
    btn_raw[0] = 1'b1;
    sched(0, d + 6, d + 46);
    go_to(d + 40);
    btn_raw[0] = 1'b0;
    go_to(d + 45);
    chk("rep_held_hold", held, 4'h1);
    go_to(d + 46);
    chk("rep_held_off", held, 4'h0);
    go_to(d + 55);

    // Simultaneous hour and mode presses.
    d = cyc;
    btn_raw = 4'b1001;
    sched(0, d + 6, d + 21);
    sched(3, d + 6, d + 21);
    go_to(d + 6);
    chk("sim_held", held, 4'b1001);
    go_to(d + 15);
    btn_raw = 4'h0;
    go_to(d + 25);

    // Enable dropped on a due repeat, then restored while held.
    d = cyc;
    btn_raw[0] = 1'b1;
    sched(0, d + 6, d + 22);
    go_to(d + 21);
    ena = 1'b0;
    go_to(d + 22);
    chk("ena_held_off", held, 4'h0);
    chk("ena_press_off", press, 4'h0);
    chk("ena_any_off", any_held, 1'b0);
    go_to(d + 25);
    f = cyc;
    ena = 1'b1;
    sched(0, f + 4, f + 26);
    go_to(f + 3);
    chk("ena_held_pre", held, 4'h0);
    go_to(f + 4);
    chk("ena_held_on", held, 4'h1);
    go_to(f + 20);
    btn_raw[0] = 1'b0;
    go_to(f + 30);

    // Asynchronous reset in the middle of a hold.
    d = cyc;
    btn_raw[2] = 1'b1;
    sched(2, d + 6, 0);
    go_to(d + 10);
    chk("ar_held_pre", held, 4'h4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_held_now", held, 4'h0);
    chk("ar_any_now", any_held, 1'b0);
    go_to(d + 12);
    rst_n = 1'b1;
    sched(2, d + 18, 0);
    go_to(d + 17);
    chk("ar_held_wait", held, 4'h0);
    go_to(d + 20);
    btn_raw[2] = 1'b0;
    go_to(d + 25);
    chk("ar_held_hold", held, 4'h4);
    go_to(d + 26);
    chk("ar_held_off", held, 4'h0);

    go_to(cyc + 15);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
